// File: rtl/ppi_sync.sv
// Clocked 8255-style parallel port: ports A/B (W bits) and C (8 bits), with mode 0,
// mode 1 strobed handshake and bit set/reset on port C.
module ppi_sync #(
  parameter int W           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic         CLK,
  input  logic         RESET_,
  input  logic         CS_,
  input  logic         RD_,
  input  logic         WR_,
  input  logic [1:0]   A,
  input  logic [W-1:0] D_IN,
  output logic [W-1:0] D_OUT,
  output logic         D_OE,
  input  logic [W-1:0] PA_IN,
  output logic [W-1:0] PA_OUT,
  output logic [W-1:0] PA_OE,
  input  logic [W-1:0] PB_IN,
  output logic [W-1:0] PB_OUT,
  output logic [W-1:0] PB_OE,
  input  logic [7:0]   PC_IN,
  output logic [7:0]   PC_OUT,
  output logic [7:0]   PC_OE,
  output logic         INTRA,
  output logic         INTRB
);

  localparam int S = SYNC_STAGES;

  logic [7:0]   ctrl;
  logic [W-1:0] pa_lat, pb_lat;
  logic [7:0]   pc_lat;
  logic [W-1:0] d_out_q;
  logic         d_oe_q;
  logic         inte_a, inte_b, ibf_a, ibf_b, obf_a_n, obf_b_n, intr_a, intr_b;
  logic [S-1:0] sync_pc4, sync_pc6, sync_pc2;
  logic         prev_pc4, prev_pc6, prev_pc2;

  logic wr_cyc, rd_cyc, mode_set, bsr, bsr_val, bsr_hits_inte;
  logic [2:0] bsr_bit;
  logic mode_a1, a_in, pcu_in, mode_b1, b_in, pcl_in;
  logic wr_pa, wr_pb, wr_pc, rd_pa, rd_pb;
  logic fall4, rise4, fall6, rise6, fall2, rise2;
  logic stb_a_fall, stb_a_rise, ack_a_fall, ack_a_rise;
  logic stb_b_fall, stb_b_rise, ack_b_fall, ack_b_rise;
  logic [7:0] pc_oe, pc_drv, pc_rd, hs_mask, pc_wmask;
  logic [W-1:0] rd_data;

  assign wr_cyc = ~CS_ & ~WR_ & RD_;
  assign rd_cyc = ~CS_ & ~RD_ & WR_;

  // A mode-set word with a reserved group A mode (bit 6 set) is dropped entirely.
  assign mode_set = wr_cyc & (A == 2'd3) & D_IN[7] & ~D_IN[6];
  assign bsr      = wr_cyc & (A == 2'd3) & ~D_IN[7];
  assign bsr_bit  = D_IN[3:1];
  assign bsr_val  = D_IN[0];

  assign mode_a1 = (ctrl[6:5] == 2'b01);
  assign a_in    = ctrl[4];
  assign pcu_in  = ctrl[3];
  assign mode_b1 = ctrl[2];
  assign b_in    = ctrl[1];
  assign pcl_in  = ctrl[0];

  assign wr_pa = wr_cyc & (A == 2'd0);
  assign wr_pb = wr_cyc & (A == 2'd1);
  assign wr_pc = wr_cyc & (A == 2'd2);
  assign rd_pa = rd_cyc & (A == 2'd0);
  assign rd_pb = rd_cyc & (A == 2'd1);

  assign bsr_hits_inte = (mode_a1 &  a_in & (bsr_bit == 3'd4))
                       | (mode_a1 & ~a_in & (bsr_bit == 3'd6))
                       | (mode_b1 & (bsr_bit == 3'd2));

  assign fall4 =  prev_pc4 & ~sync_pc4[S-1];
  assign rise4 = ~prev_pc4 &  sync_pc4[S-1];
  assign fall6 =  prev_pc6 & ~sync_pc6[S-1];
  assign rise6 = ~prev_pc6 &  sync_pc6[S-1];
  assign fall2 =  prev_pc2 & ~sync_pc2[S-1];
  assign rise2 = ~prev_pc2 &  sync_pc2[S-1];

  assign stb_a_fall = mode_a1 &  a_in & fall4;
  assign stb_a_rise = mode_a1 &  a_in & rise4;
  assign ack_a_fall = mode_a1 & ~a_in & fall6;
  assign ack_a_rise = mode_a1 & ~a_in & rise6;
  assign stb_b_fall = mode_b1 &  b_in & fall2;
  assign stb_b_rise = mode_b1 &  b_in & rise2;
  assign ack_b_fall = mode_b1 & ~b_in & fall2;
  assign ack_b_rise = mode_b1 & ~b_in & rise2;

  // Port C: nibble defaults, then mode-1 handshake bits override direction and value.
  always_comb begin
    pc_oe   = {{4{~pcu_in}}, {4{~pcl_in}}};
    pc_drv  = pc_lat;
    hs_mask = '0;
    pc_rd   = (pc_lat & pc_oe) | (PC_IN & ~pc_oe);
    if (mode_a1) begin
      hs_mask[3] = 1'b1;
      pc_oe[3]   = 1'b1;
      pc_drv[3]  = intr_a;
      pc_rd[3]   = intr_a;
      if (a_in) begin
        hs_mask[5:4] = 2'b11;
        pc_oe[5:4]   = 2'b10;
        pc_drv[5]    = ibf_a;
        pc_rd[5]     = ibf_a;
        pc_rd[4]     = inte_a;
      end else begin
        hs_mask[7:6] = 2'b11;
        pc_oe[7:6]   = 2'b10;
        pc_drv[7]    = obf_a_n;
        pc_rd[7]     = obf_a_n;
        pc_rd[6]     = inte_a;
      end
    end
    if (mode_b1) begin
      hs_mask[2:0] = 3'b111;
      pc_oe[2:0]   = 3'b011;
      pc_drv[1]    = b_in ? ibf_b : obf_b_n;
      pc_rd[1]     = b_in ? ibf_b : obf_b_n;
      pc_drv[0]    = intr_b;
      pc_rd[0]     = intr_b;
      pc_rd[2]     = inte_b;
    end
    pc_wmask = pc_oe & ~hs_mask;
  end

  always_comb begin
    rd_data = '0;
    case (A)
      2'd0:    rd_data = (a_in & ~mode_a1) ? PA_IN : pa_lat;
      2'd1:    rd_data = (b_in & ~mode_b1) ? PB_IN : pb_lat;
      2'd2:    rd_data[7:0] = pc_rd;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      sync_pc4 <= '1;
      sync_pc6 <= '1;
      sync_pc2 <= '1;
      prev_pc4 <= 1'b1;
      prev_pc6 <= 1'b1;
      prev_pc2 <= 1'b1;
    end else begin
      sync_pc4 <= {sync_pc4[S-2:0], PC_IN[4]};
      sync_pc6 <= {sync_pc6[S-2:0], PC_IN[6]};
      sync_pc2 <= {sync_pc2[S-2:0], PC_IN[2]};
      prev_pc4 <= sync_pc4[S-1];
      prev_pc6 <= sync_pc6[S-1];
      prev_pc2 <= sync_pc2[S-1];
    end
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      ctrl    <= 8'h9B;
      d_out_q <= '0;
      d_oe_q  <= 1'b0;
      pc_lat  <= '0;
    end else begin
      d_oe_q  <= rd_cyc;
      d_out_q <= rd_cyc ? rd_data : '0;
      if (mode_set) begin
        ctrl   <= D_IN[7:0];
        pc_lat <= '0;
      end else if (wr_pc) begin
        pc_lat <= (pc_lat & ~pc_wmask) | (D_IN[7:0] & pc_wmask);
      end else if (bsr && !bsr_hits_inte) begin
        pc_lat[bsr_bit] <= bsr_val;
      end
    end
  end

  // Within each group, later statements win: a read clears INTR after a strobe rise,
  // a strobe capture sets IBF after a read, and a data write clears OBF_ after an ACK fall.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      pa_lat  <= '0;
      inte_a  <= 1'b0;
      ibf_a   <= 1'b0;
      obf_a_n <= 1'b1;
      intr_a  <= 1'b0;
    end else if (mode_set) begin
      pa_lat  <= '0;
      inte_a  <= 1'b0;
      ibf_a   <= 1'b0;
      obf_a_n <= 1'b1;
      intr_a  <= 1'b0;
    end else begin
      if (mode_a1 && a_in) begin
        if (stb_a_rise && ibf_a && inte_a) intr_a <= 1'b1;
        if (rd_pa) begin
          intr_a <= 1'b0;
          ibf_a  <= 1'b0;
        end
        if (stb_a_fall) begin
          pa_lat <= PA_IN;
          ibf_a  <= 1'b1;
        end
      end else begin
        if (ack_a_fall) obf_a_n <= 1'b1;
        if (ack_a_rise && obf_a_n && inte_a) intr_a <= 1'b1;
        if (wr_pa && !a_in) begin
          pa_lat <= D_IN;
          if (mode_a1) begin
            obf_a_n <= 1'b0;
            intr_a  <= 1'b0;
          end
        end
      end
      if (bsr && mode_a1 && ((a_in && bsr_bit == 3'd4) || (!a_in && bsr_bit == 3'd6)))
        inte_a <= bsr_val;
    end
  end

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      pb_lat  <= '0;
      inte_b  <= 1'b0;
      ibf_b   <= 1'b0;
      obf_b_n <= 1'b1;
      intr_b  <= 1'b0;
    end else if (mode_set) begin
      pb_lat  <= '0;
      inte_b  <= 1'b0;
      ibf_b   <= 1'b0;
      obf_b_n <= 1'b1;
      intr_b  <= 1'b0;
    end else begin
      if (mode_b1 && b_in) begin
        if (stb_b_rise && ibf_b && inte_b) intr_b <= 1'b1;
        if (rd_pb) begin
          intr_b <= 1'b0;
          ibf_b  <= 1'b0;
        end
        if (stb_b_fall) begin
          pb_lat <= PB_IN;
          ibf_b  <= 1'b1;
        end
      end else begin
        if (ack_b_fall) obf_b_n <= 1'b1;
        if (ack_b_rise && obf_b_n && inte_b) intr_b <= 1'b1;
        if (wr_pb && !b_in) begin
          pb_lat <= D_IN;
          if (mode_b1) begin
            obf_b_n <= 1'b0;
            intr_b  <= 1'b0;
          end
        end
      end
      if (bsr && mode_b1 && bsr_bit == 3'd2) inte_b <= bsr_val;
    end
  end

  assign D_OUT  = d_out_q;
  assign D_OE   = d_oe_q;
  assign PA_OUT = pa_lat;
  assign PB_OUT = pb_lat;
  assign PA_OE  = {W{~a_in}};
  assign PB_OE  = {W{~b_in}};
  assign PC_OUT = pc_drv;
  assign PC_OE  = pc_oe;
  assign INTRA  = intr_a;
  assign INTRB  = intr_b;

endmodule

// File: tb/tb_ppi_sync.sv
// Directed bench for ppi_sync: reset, mode 0, BSR, mode 1 input/output handshakes,
// simultaneous-event cases and asynchronous reset mid-handshake.
module tb_ppi_sync;

  logic       CLK = 1'b0;
  logic       RESET_, CS_, RD_, WR_;
  logic [1:0] A;
  logic [7:0] D_IN, D_OUT, PA_IN, PA_OUT, PA_OE, PB_IN, PB_OUT, PB_OE;
  logic [7:0] PC_IN, PC_OUT, PC_OE;
  logic       D_OE, INTRA, INTRB;

  int tests = 0;
  int failed = 0;

  logic [7:0] rd;
  logic       rd_oe;

  ppi_sync #(.W(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RESET_(RESET_), .CS_(CS_), .RD_(RD_), .WR_(WR_), .A(A),
    .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
    .PA_IN(PA_IN), .PA_OUT(PA_OUT), .PA_OE(PA_OE),
    .PB_IN(PB_IN), .PB_OUT(PB_OUT), .PB_OE(PB_OE),
    .PC_IN(PC_IN), .PC_OUT(PC_OUT), .PC_OE(PC_OE),
    .INTRA(INTRA), .INTRB(INTRB)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK);
    CS_ = 1'b0; WR_ = 1'b0; RD_ = 1'b1; A = a; D_IN = d;
    tick();
    CS_ = 1'b1; WR_ = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d, output logic oe);
    @(negedge CLK);
    CS_ = 1'b0; RD_ = 1'b0; WR_ = 1'b1; A = a;
    tick();
    d = D_OUT; oe = D_OE;
    CS_ = 1'b1; RD_ = 1'b1;
  endtask

  task automatic test_reset();
    RESET_ = 1'b0; CS_ = 1'b1; RD_ = 1'b1; WR_ = 1'b1; A = 2'd0; D_IN = 8'h00;
    PA_IN = 8'h00; PB_IN = 8'h00; PC_IN = 8'hFF;
    #12;
    tests++; if (PA_OE !== 8'h00 || PB_OE !== 8'h00 || PC_OE !== 8'h00) begin failed++; $display("FAIL reset_oe got %h/%h/%h exp 00/00/00", PA_OE, PB_OE, PC_OE); end
    tests++; if (PA_OUT !== 8'h00 || PB_OUT !== 8'h00 || PC_OUT !== 8'h00) begin failed++; $display("FAIL reset_out got %h/%h/%h exp 00/00/00", PA_OUT, PB_OUT, PC_OUT); end
    tests++; if (D_OUT !== 8'h00 || D_OE !== 1'b0 || INTRA !== 1'b0 || INTRB !== 1'b0) begin failed++; $display("FAIL reset_misc got dout=%h doe=%b intra=%b intrb=%b exp 00 0 0 0", D_OUT, D_OE, INTRA, INTRB); end
    @(negedge CLK); RESET_ = 1'b1;
    bus_read(2'd3, rd, rd_oe);
    tests++; if (rd !== 8'h00 || rd_oe !== 1'b1) begin failed++; $display("FAIL reset_read_ctrl got %h oe=%b exp 00 oe=1", rd, rd_oe); end
  endtask

  task automatic test_mode0();
    bus_write(2'd3, 8'h80);
    tests++; if (PA_OE !== 8'hFF || PB_OE !== 8'hFF || PC_OE !== 8'hFF) begin failed++; $display("FAIL m0_oe got %h/%h/%h exp FF/FF/FF", PA_OE, PB_OE, PC_OE); end
    bus_write(2'd0, 8'h5A);
    tests++; if (PA_OUT !== 8'h5A) begin failed++; $display("FAIL m0_pa_out got %h exp 5A", PA_OUT); end
    bus_write(2'd3, 8'hC0);
    tests++; if (PA_OE !== 8'hFF || PA_OUT !== 8'h5A) begin failed++; $display("FAIL m0_reserved_ignored got oe=%h out=%h exp FF 5A", PA_OE, PA_OUT); end
    bus_write(2'd3, 8'h82);
    tests++; if (PA_OUT !== 8'h00 || PB_OE !== 8'h00) begin failed++; $display("FAIL m0_modeset_clear got pa_out=%h pb_oe=%h exp 00 00", PA_OUT, PB_OE); end
    PB_IN = 8'h3C;
    bus_read(2'd1, rd, rd_oe);
    tests++; if (rd !== 8'h3C || rd_oe !== 1'b1) begin failed++; $display("FAIL m0_read_pb got %h oe=%b exp 3C oe=1", rd, rd_oe); end
    bus_read(2'd3, rd, rd_oe);
    tests++; if (rd !== 8'h00 || rd_oe !== 1'b1) begin failed++; $display("FAIL b2b_read got %h oe=%b exp 00 oe=1", rd, rd_oe); end
    tick();
    tests++; if (D_OE !== 1'b0) begin failed++; $display("FAIL doe_one_cycle got %b exp 0", D_OE); end
    bus_write(2'd3, 8'h88);
    bus_write(2'd2, 8'hFF);
    tests++; if (PC_OUT !== 8'h0F || PC_OE !== 8'h0F) begin failed++; $display("FAIL m0_pc_write got out=%h oe=%h exp 0F 0F", PC_OUT, PC_OE); end
    PC_IN = 8'hA0;
    bus_read(2'd2, rd, rd_oe);
    tests++; if (rd !== 8'hAF) begin failed++; $display("FAIL m0_pc_read got %h exp AF", rd); end
    PC_IN = 8'hFF;
  endtask

  task automatic test_bsr();
    bus_write(2'd3, 8'h90);
    bus_write(2'd3, 8'h0B);
    tests++; if (PC_OUT !== 8'h20) begin failed++; $display("FAIL bsr_set got %h exp 20", PC_OUT); end
    bus_write(2'd3, 8'h0A);
    tests++; if (PC_OUT !== 8'h00) begin failed++; $display("FAIL bsr_clr got %h exp 00", PC_OUT); end
    PA_IN = 8'hA5;
    bus_read(2'd0, rd, rd_oe);
    tests++; if (rd !== 8'hA5 || PC_OE !== 8'hFF) begin failed++; $display("FAIL bsr_ctrl_kept got rd=%h pc_oe=%h exp A5 FF", rd, PC_OE); end
  endtask

  task automatic test_mode1_in();
    PC_IN = 8'hFF;
    bus_write(2'd3, 8'hB0);
    bus_write(2'd3, 8'h09);
    tests++; if (PC_OE !== 8'hEF || PC_OUT !== 8'h00) begin failed++; $display("FAIL m1in_pc got oe=%h out=%h exp EF 00", PC_OE, PC_OUT); end
    bus_read(2'd2, rd, rd_oe);
    tests++; if (rd !== 8'h10) begin failed++; $display("FAIL m1in_inte_read got %h exp 10", rd); end
    @(negedge CLK); PA_IN = 8'hC3; PC_IN = 8'hEF;
    tick(); tick();
    tests++; if (PC_OUT[5] !== 1'b0) begin failed++; $display("FAIL m1in_ibf_early got %b exp 0", PC_OUT[5]); end
    tick();
    tests++; if (PC_OUT !== 8'h20) begin failed++; $display("FAIL m1in_ibf_set got %h exp 20", PC_OUT); end
    tick();
    @(negedge CLK); PC_IN = 8'hFF;
    tick(); tick();
    tests++; if (INTRA !== 1'b0) begin failed++; $display("FAIL m1in_intr_early got %b exp 0", INTRA); end
    tick();
    tests++; if (INTRA !== 1'b1 || PC_OUT !== 8'h28) begin failed++; $display("FAIL m1in_intr_set got intra=%b pc=%h exp 1 28", INTRA, PC_OUT); end
    PA_IN = 8'h00;
    bus_read(2'd0, rd, rd_oe);
    tests++; if (rd !== 8'hC3 || rd_oe !== 1'b1) begin failed++; $display("FAIL m1in_read got %h oe=%b exp C3 1", rd, rd_oe); end
    tests++; if (INTRA !== 1'b0 || PC_OUT !== 8'h00) begin failed++; $display("FAIL m1in_read_clear got intra=%b pc=%h exp 0 00", INTRA, PC_OUT); end
  endtask

  task automatic test_read_stb_collision();
    @(negedge CLK); PA_IN = 8'h11; PC_IN = 8'hEF;
    tick(); tick();
    bus_read(2'd0, rd, rd_oe);
    tests++; if (rd !== 8'hC3) begin failed++; $display("FAIL coll_old_data got %h exp C3", rd); end
    tests++; if (PC_OUT !== 8'h20 || INTRA !== 1'b0) begin failed++; $display("FAIL coll_ibf got pc=%h intra=%b exp 20 0", PC_OUT, INTRA); end
    @(negedge CLK); PC_IN = 8'hFF;
    tick(); tick(); tick();
    tests++; if (INTRA !== 1'b1) begin failed++; $display("FAIL coll_intr got %b exp 1", INTRA); end
    bus_read(2'd0, rd, rd_oe);
    tests++; if (rd !== 8'h11) begin failed++; $display("FAIL coll_new_data got %h exp 11", rd); end
  endtask

  task automatic test_mode1_out();
    PC_IN = 8'hFF;
    bus_write(2'd3, 8'h84);
    bus_write(2'd3, 8'h05);
    tests++; if (PC_OE !== 8'hFB || PC_OUT !== 8'h02 || PB_OE !== 8'hFF) begin failed++; $display("FAIL m1out_setup got oe=%h pc=%h pb_oe=%h exp FB 02 FF", PC_OE, PC_OUT, PB_OE); end
    bus_write(2'd1, 8'h77);
    tests++; if (PB_OUT !== 8'h77 || PC_OUT !== 8'h00) begin failed++; $display("FAIL m1out_write got pb=%h pc=%h exp 77 00", PB_OUT, PC_OUT); end
    @(negedge CLK); PC_IN = 8'hFB;
    tick(); tick();
    tests++; if (PC_OUT[1] !== 1'b0) begin failed++; $display("FAIL m1out_obf_early got %b exp 0", PC_OUT[1]); end
    tick();
    tests++; if (PC_OUT !== 8'h02) begin failed++; $display("FAIL m1out_obf_set got %h exp 02", PC_OUT); end
    tick();
    @(negedge CLK); PC_IN = 8'hFF;
    tick(); tick(); tick();
    tests++; if (INTRB !== 1'b1 || PC_OUT !== 8'h03) begin failed++; $display("FAIL m1out_intr got intrb=%b pc=%h exp 1 03", INTRB, PC_OUT); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); PC_IN = 8'hFB;
    tick();
    #2 RESET_ = 1'b0;
    #1;
    tests++; if (PB_OUT !== 8'h00 || PB_OE !== 8'h00 || PC_OE !== 8'h00 || PC_OUT !== 8'h00 || INTRB !== 1'b0) begin failed++; $display("FAIL reset_mid got pb=%h pb_oe=%h pc_oe=%h pc=%h intrb=%b exp 00 00 00 00 0", PB_OUT, PB_OE, PC_OE, PC_OUT, INTRB); end
    PC_IN = 8'hFF;
    @(negedge CLK); RESET_ = 1'b1;
  endtask

  task automatic test_write_ack_collision();
    bus_write(2'd3, 8'h84);
    bus_write(2'd3, 8'h05);
    bus_write(2'd1, 8'h77);
    @(negedge CLK); PC_IN = 8'hFB;
    tick(); tick();
    bus_write(2'd1, 8'h99);
    tests++; if (PB_OUT !== 8'h99 || PC_OUT[1] !== 1'b0) begin failed++; $display("FAIL wr_ack_coll got pb=%h obf=%b exp 99 0", PB_OUT, PC_OUT[1]); end
    @(negedge CLK); PC_IN = 8'hFF;
    tick(); tick(); tick();
    tests++; if (INTRB !== 1'b0) begin failed++; $display("FAIL wr_ack_coll_intr got %b exp 0", INTRB); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_bsr();
    test_mode1_in();
    test_read_stb_collision();
    test_mode1_out();
    test_reset_mid();
    test_write_ack_collision();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ppi_sync.md
# ppi_sync

Clocked, parametrised successor to the asynchronous 8255-style PPI. It provides two W-bit data ports (A, B) and an 8-bit port C on separate in/out/enable pins, with three modes:

- mode 0: simple I/O;
- mode 1: strobed handshake I/O with interrupt request;
- BSR: bit set/reset on port C.

It sits between a processor bus (synchronous to CLK) and external peripherals. All state is registered.

## Interface
Parameters:
- W, 8: width of ports A/B and of the data bus; W >= 8. The control word is D_IN[7:0].
- SYNC_STAGES, 2: flops in the synchroniser on each handshake input (STB_/ACK_ pins in port C); minimum 2.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET_  in  1  asynchronous, active-low reset.
- CS_, RD_, WR_  in  1 each  active-low chip select, read strobe and write strobe; sampled on CLK.
- A  in  2  register select: 0 = port A, 1 = port B, 2 = port C, 3 = control.
- D_IN  in  W  write data.
- D_OUT  out  W  read data.
- D_OE  out  1  high when D_OUT is valid.
- PA_IN / PA_OUT / PA_OE  in/out/out  W  port A pins, output latch and per-bit drive enable.
- PB_IN / PB_OUT / PB_OE  in/out/out  W  port B, same arrangement.
- PC_IN / PC_OUT / PC_OE  in/out/out  8  port C, same arrangement.
- INTRA, INTRB  out  1  interrupt requests; each mirrors its PC bit (PC3, PC0).

## Operation
- **Bus cycle.** A write happens on an edge where CS_=0, WR_=0, RD_=1. A read happens on an edge where CS_=0, RD_=0, WR_=1. With RD_=WR_=0 the cycle is ignored. A read with A=3 returns 0.
- **Control write, mode set (D_IN[7]=1).**
  - Field layout: [6:5] group A mode (00 = mode 0, 01 = mode 1, 1x = reserved, whole word ignored); [4] PA is input; [3] PC7..4 are input; [2] group B mode (0/1); [1] PB is input; [0] PC3..0 are input.
  - Effects: CTRL is updated. Every output latch is cleared to 0, all INTE flags to 0, IBF to 0, OBF_ to 1, INTR to 0.
- **Control write, BSR (D_IN[7]=0).**
  - Updates PC latch bit D_IN[3:1] to D_IN[0]. CTRL is unchanged.
  - If that bit is an INTE bit of an active mode-1 group, INTE is updated instead: PC4 = INTE A when A is an input, PC6 = INTE A when A is an output, PC2 = INTE B.
- **Mode 0.**
  - Output port: the data write updates the latch; PA/PB_OE are all 1s.
  - Input port: PA/PB_OE are 0; a read returns the pins sampled at the read edge.
  - PC nibbles follow CTRL[3] and CTRL[0].
- **Mode 1, group A handshake bits.**
  - Input: PC4 = STBA_ (in), PC5 = IBFA (out), PC3 = INTRA.
  - Output: PC7 = OBFA_ (out), PC6 = ACKA_ (in), PC3 = INTRA.
  - The remaining upper PC bits follow CTRL[3]; handshake bits override the nibble direction.
- **Mode 1, group B handshake bits.**
  - Input: PC2 = STBB_, PC1 = IBFB, PC0 = INTRB.
  - Output: PC2 = ACKB_, PC1 = OBFB_, PC0 = INTRB.
- **Mode 1 input.**
  - On a synchronised falling edge of STB_, the port latch captures the pins and IBF is set to 1.
  - On a synchronised rising edge of STB_, INTR is set if IBF=1 and INTE=1.
  - A read of the port returns the latch and clears INTR and IBF.
  - A further STB_ while IBF=1 overwrites the latch.
- **Mode 1 output.**
  - A data write loads the latch, clears OBF_ to 0 and clears INTR.
  - A synchronised falling edge of ACK_ sets OBF_ to 1.
  - A synchronised rising edge of ACK_ sets INTR if OBF_=1 and INTE=1.
- **Port C read.** Input bits return the pins. Output bits return the latch. Handshake outputs return their status. INTE bit positions return INTE. A data write to port C changes only non-handshake output bits.

## Timing
- **Reset values.**
  - CTRL=8'h9B: all ports are mode-0 inputs.
  - PA/PB/PC_OUT = 0, all OE = 0, D_OUT = 0, D_OE = 0, INTRA = INTRB = 0, all INTE = 0, IBF = 0, OBF_ = 1.
  - Reset asserted mid-handshake aborts immediately to these values. The synchronisers reset to 1.
- **Write latency.** A write takes effect on the sampling edge; the new value is visible on pins/OE after that edge.
- **Read latency.** D_OUT and D_OE are registered and appear 1 cycle after the read edge. D_OE is high for exactly one cycle per read edge, so back-to-back reads give a continuous D_OE.
- **Handshake latency.**
  - A pin edge at clock n is seen at edge n+SYNC_STAGES; IBF/OBF_ change on the following edge.
  - The STB_ low period and the data setup must each cover at least SYNC_STAGES+1 cycles.
- **Simultaneous events.**
  - Port read on the same edge as an STB_ capture: D_OUT returns the old latch; IBF remains 1; INTR is cleared.
  - Data write on the same edge as an ACK_ falling edge: the write wins and OBF_=0.
  - Mode-set write on the same edge as a handshake edge: the mode set wins.

## Test plan
- **Reset and mode 0.** Release reset → all OE=0 and read of A=3 returns 0. Write 8'h80 then PA=8'h5A → PA_OE=FF, PA_OUT=5A. Read A=1 with PB_IN=8'h3C → D_OUT=3C one cycle later with D_OE=1.
- **BSR.** Set 8'h80 mode, then BSR write 8'h0B (bit5=1) → PC_OUT[5]=1. Then BSR 8'h0A → PC_OUT[5]=0. CTRL unchanged: reading port A still follows mode 0.
- **Mode 1 input, group A.** Control 8'hB0, BSR 8'h09 (INTE A=1). Pulse STBA_ low for 4 cycles with PA_IN=8'hC3 → IBFA=1 at edge +3 after fall; INTRA=1 after rise. Read port A → D_OUT=C3, INTRA=0, IBFA=0.
- **Mode 1 output, group B.** Control 8'h84, BSR 8'h05. Write PB=8'h77 → OBFB_=0, PB_OUT=77. Pulse ACKB_ → OBFB_=1, then INTRB=1 on rise.
- **Collision.** Port-A read on the same edge as the STB capture → old data returned, IBFA stays 1.
- **Reset mid-handshake.** Drop RESET_ mid-handshake → all outputs at reset values asynchronously.
